// File: rtl/set_associative.sv
// 2-way set-associative read-only byte cache. Misses fetch one 32-bit line
// from a fixed-latency backing memory and allocate it into the victim way.
module set_associative #(
    parameter int NUM_SETS    = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_out,
    input  logic [31:0] memory_in,
    output logic [31:0] memory_out,
    output logic        read_en,
    output logic [7:0]  core_in,
    output logic        flag_hit,
    output logic        flag_miss,
    output logic        core_ready
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 30 - INDEX_W;
    localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic [31:0]      addr_r;
    logic             first_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      memory_out_r;
    logic             read_en_r;
    logic [7:0]       core_in_r;
    logic             flag_hit_r;
    logic             flag_miss_r;
    logic             core_ready_r;

    logic [NUM_SETS-1:0] valid0_r;
    logic [NUM_SETS-1:0] valid1_r;
    logic [NUM_SETS-1:0] lru_r;
    logic [TAG_W-1:0]    tag0_r  [NUM_SETS];
    logic [TAG_W-1:0]    tag1_r  [NUM_SETS];
    logic [31:0]         data0_r [NUM_SETS];
    logic [31:0]         data1_r [NUM_SETS];

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [1:0]         off_s;
    logic               hit0_s;
    logic               hit1_s;
    logic               hit_s;
    logic [31:0]        hit_data_s;
    logic               victim_s;
    logic               accept_s;
    logic               cnt_zero_s;
    logic               fill_s;

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    assign idx_s = addr_r[INDEX_W+1:2];
    assign tag_s = addr_r[31:INDEX_W+2];
    assign off_s = addr_r[1:0];

    // Tag compare, hit data select and victim choice for the latched address
    always_comb begin
        hit0_s     = valid0_r[idx_s] && (tag0_r[idx_s] == tag_s);
        hit1_s     = valid1_r[idx_s] && (tag1_r[idx_s] == tag_s);
        hit_s      = hit0_s || hit1_s;
        hit_data_s = data1_r[idx_s];
        victim_s   = lru_r[idx_s];
        if (hit0_s) begin
            hit_data_s = data0_r[idx_s];
        end else begin
            hit_data_s = data1_r[idx_s];
        end
        if (!valid0_r[idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid1_r[idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[idx_s];
        end
    end

    // Request acceptance and fill-completion strobes
    always_comb begin
        accept_s   = (state_r == IDLE) && (first_r || (core_out != addr_r));
        cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
        fill_s     = (state_r == MEM_WAIT) && cnt_zero_s;
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = LOOKUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    next_state_s = RESPOND;
                end else begin
                    next_state_s = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (cnt_zero_s) begin
                    next_state_s = RESPOND;
                end else begin
                    next_state_s = MEM_WAIT;
                end
            end
            RESPOND: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, memory handshake and core-facing output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r       <= 32'h0000_0000;
            first_r      <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
            memory_out_r <= 32'h0000_0000;
            read_en_r    <= 1'b0;
            core_in_r    <= 8'h00;
            flag_hit_r   <= 1'b0;
            flag_miss_r  <= 1'b0;
            core_ready_r <= 1'b0;
        end else begin
            // ready is high exactly during the RESPOND cycle
            core_ready_r <= ((state_r == LOOKUP) && hit_s) || fill_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r      <= core_out;
                        first_r     <= 1'b0;
                        flag_hit_r  <= 1'b0;
                        flag_miss_r <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        core_in_r  <= select_byte(hit_data_s, off_s);
                        flag_hit_r <= 1'b1;
                    end else begin
                        flag_miss_r  <= 1'b1;
                        read_en_r    <= 1'b1;
                        memory_out_r <= {addr_r[31:2], 2'b00};
                        cnt_r        <= CNT_W'(MEM_LATENCY);
                    end
                end
                MEM_WAIT: begin
                    if (cnt_zero_s) begin
                        core_in_r <= select_byte(memory_in, off_s);
                        read_en_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Cache storage: replacement state on hits, allocation on fill completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0_r <= {NUM_SETS{1'b0}};
            valid1_r <= {NUM_SETS{1'b0}};
            lru_r    <= {NUM_SETS{1'b0}};
            for (int i = 0; i < NUM_SETS; i++) begin
                tag0_r[i]  <= {TAG_W{1'b0}};
                tag1_r[i]  <= {TAG_W{1'b0}};
                data0_r[i] <= 32'h0000_0000;
                data1_r[i] <= 32'h0000_0000;
            end
        end else begin
            if ((state_r == LOOKUP) && hit_s) begin
                lru_r[idx_s] <= hit0_s;
            end else if (fill_s) begin
                if (victim_s) begin
                    valid1_r[idx_s] <= 1'b1;
                    tag1_r[idx_s]   <= tag_s;
                    data1_r[idx_s]  <= memory_in;
                end else begin
                    valid0_r[idx_s] <= 1'b1;
                    tag0_r[idx_s]   <= tag_s;
                    data0_r[idx_s]  <= memory_in;
                end
                lru_r[idx_s] <= ~victim_s;
            end
        end
    end

    assign memory_out = memory_out_r;
    assign read_en    = read_en_r;
    assign core_in    = core_in_r;
    assign flag_hit   = flag_hit_r;
    assign flag_miss  = flag_miss_r;
    assign core_ready = core_ready_r;

endmodule

// File: tb/tb_set_associative.sv
// Directed bench for set_associative: table of accesses with hand-computed
// hit/miss and byte results, plus hold and reset-during-fill sequences.
module tb_set_associative;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] core_out;
    logic [31:0] memory_in;
    logic [31:0] memory_out;
    logic        read_en;
    logic [7:0]  core_in;
    logic        flag_hit;
    logic        flag_miss;
    logic        core_ready;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [19];

    set_associative #(.NUM_SETS(16), .MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_out   (core_out),
        .memory_in  (memory_in),
        .memory_out (memory_out),
        .read_en    (read_en),
        .core_in    (core_in),
        .flag_hit   (flag_hit),
        .flag_miss  (flag_miss),
        .core_ready (core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: line 0x4 holds DDCCBBAA, every other line is
    // {~a[15:8], ~a[7:0], a[15:8], a[7:0]} of its line address a.
    always_comb begin
        if (memory_out == 32'h0000_0004) begin
            memory_in = 32'hDDCC_BBAA;
        end else begin
            memory_in = {~memory_out[15:8], ~memory_out[7:0], memory_out[15:8], memory_out[7:0]};
        end
    end

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, id, act, exp);
        end
    endtask

    // Presents an address, waits for core_ready and checks latency, flags,
    // byte, memory request activity and the one-cycle ready pulse.
    task automatic run_access(input logic [31:0] addr, input logic exp_hit, input logic [7:0] exp_byte, input int id);
        int   k;
        int   ren_cnt;
        logic mo_ok;
        core_out = addr;
        k        = 0;
        ren_cnt  = 0;
        mo_ok    = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (read_en) begin
                ren_cnt++;
                if (memory_out !== {addr[31:2], 2'b00}) mo_ok = 1'b0;
            end
        end while (!core_ready && k < 40);
        check("latency",    id, 32'(k), exp_hit ? 32'd2 : 32'(3 + LAT));
        check("flag_hit",   id, {31'd0, flag_hit}, {31'd0, exp_hit});
        check("flag_miss",  id, {31'd0, flag_miss}, {31'd0, ~exp_hit});
        check("core_in",    id, {24'd0, core_in}, {24'd0, exp_byte});
        // read_en is held through the cycle in which the line is captured
        check("read_en_cycles", id, 32'(ren_cnt), exp_hit ? 32'd0 : 32'(LAT + 1));
        check("memory_out", id, {31'd0, mo_ok}, 32'd1);
        @(negedge clk);
        check("ready_pulse", id, {31'd0, core_ready}, 32'd0);
    endtask

    initial begin
        int rdy_cnt;
        int ren_cnt;
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        core_out = 32'h0000_0000;

        vecs[0]  = '{32'h0000_1461, 1'b0, 8'h14};
        vecs[1]  = '{32'h0000_512D, 1'b0, 8'h51};
        vecs[2]  = '{32'h0000_1461, 1'b1, 8'h14};
        vecs[3]  = '{32'h0000_F257, 1'b0, 8'h0D};
        vecs[4]  = '{32'h0000_1461, 1'b1, 8'h14};
        vecs[5]  = '{32'h0000_F634, 1'b0, 8'h34};
        vecs[6]  = '{32'h0000_7D6B, 1'b0, 8'h82};
        vecs[7]  = '{32'h0000_8863, 1'b0, 8'h77};
        vecs[8]  = '{32'h0000_512D, 1'b1, 8'h51};
        vecs[9]  = '{32'h0000_8863, 1'b1, 8'h77};
        vecs[10] = '{32'h0000_1461, 1'b1, 8'h14};
        vecs[11] = '{32'h0000_2461, 1'b0, 8'h24};
        vecs[12] = '{32'h0000_1461, 1'b1, 8'h14};
        vecs[13] = '{32'h0000_8863, 1'b0, 8'h77};
        vecs[14] = '{32'h0000_0004, 1'b0, 8'hAA};
        vecs[15] = '{32'h0000_0005, 1'b1, 8'hBB};
        vecs[16] = '{32'h0000_0006, 1'b1, 8'hCC};
        vecs[17] = '{32'h0000_0007, 1'b1, 8'hDD};
        vecs[18] = '{32'h0000_1461, 1'b1, 8'h14};

        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 0, {memory_out[7:0], core_in, 4'd0, read_en, flag_hit, flag_miss, core_ready}, 32'd0);
        check("rst_memory_out", 0, memory_out, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_access(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_byte, i);
        end

        // Holding the last address must not start another access
        rdy_cnt = 0;
        ren_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_ready) rdy_cnt++;
            if (read_en) ren_cnt++;
        end
        check("hold_ready", 100, 32'(rdy_cnt), 32'd0);
        check("hold_read_en", 100, 32'(ren_cnt), 32'd0);
        check("hold_core_in", 100, {24'd0, core_in}, 32'h14);
        check("hold_flag_hit", 100, {31'd0, flag_hit}, 32'd1);

        // Asynchronous reset in the middle of a fill
        core_out = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        check("midfill_read_en", 200, {31'd0, read_en}, 32'd1);
        check("midfill_memory_out", 200, memory_out, 32'h0000_0300);
        #2 rst = 1'b0;
        #1;
        check("midfill_rst_outputs", 200, {core_in, 20'd0, read_en, flag_hit, flag_miss, core_ready}, 32'd0);
        check("midfill_rst_memory_out", 200, memory_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_access(32'h0000_0300, 1'b0, 8'h00, 201);
        run_access(32'h0000_1461, 1'b0, 8'h14, 202);
        run_access(32'h0000_0300, 1'b1, 8'h00, 203);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
